// File: rtl/nand_gate_chk_pkg.sv
// Shared types and defaults for the NAND gate response checker.
package nand_gate_chk_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nand_gate_resp_checker_if.sv
// Sample-tuple handshake between the NAND gate stage and its checker.
interface nand_gate_resp_checker_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_y;

  modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);

endinterface

// File: rtl/nand_gate_resp_checker.sv
// Checks y == ~(a & b) on each accepted sample over a programmed run length,
// counting pass/fail and capturing the first mismatch.
module nand_gate_resp_checker
  import nand_gate_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  nand_gate_resp_checker_if.slave   s_if,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          first_fail_idx,
  output logic [WIDTH-1:0]          first_fail_y,
  output logic [WIDTH-1:0]          first_fail_exp
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   ffi_q, ffi_d;
  logic [WIDTH-1:0]   ffy_q, ffy_d;
  logic [WIDTH-1:0]   ffe_q, ffe_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   exp_c;
  logic               accept_c;
  logic [CNT_W-1:0]   idx_c;

  // State register and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      ffi_q   <= '0;
      ffy_q   <= '0;
      ffe_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffy_q   <= ffy_d;
      ffe_q   <= ffe_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, scoring and first-failure capture
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    ffy_d    = ffy_q;
    ffe_d    = ffe_q;
    exp_c    = ~(s_if.in_a & s_if.in_b);
    accept_c = s_if.in_valid & ready_q;
    // Samples accepted so far is the 0-based index of the current one
    idx_c    = pass_q + fail_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          err_d   = 1'b0;
          ffi_d   = '0;
          ffy_d   = '0;
          ffe_d   = '0;
          num_d   = num_samples;
          state_d = (num_samples != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept_c) begin
          if (s_if.in_y == exp_c) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            fail_d = fail_q + CNT_W'(1);
            if (!err_q) begin
              err_d = 1'b1;
              ffi_d = idx_c;
              ffy_d = s_if.in_y;
              ffe_d = exp_c;
            end
          end
          if (idx_c == num_q - CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  assign s_if.in_ready  = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign err_sticky     = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_y   = ffy_q;
  assign first_fail_exp = ffe_q;

endmodule

// File: doc/nand_gate_resp_checker.md
Name: nand_gate_resp_checker

Overview:
- Downstream consumer of the NAND gate stage: takes (a, b, y) sample tuples over a valid/ready handshake and checks y == ~(a & b) bitwise.
- Counts pass/fail over a programmed run length, keeps a sticky error flag and captures the first failing sample.
- Used as a synthesizable self-check at the NAND gate output in block and FPGA benches.

Parameters:
- WIDTH, 1, bit width of a, b and y; bitwise NAND across all bits.
- CNT_W, 16, width of the run-length, counter and index fields.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; arms a run of num_samples samples
- num_samples  input  CNT_W  run length, sampled when start is accepted
- in_valid  input  1  sample tuple valid
- in_ready  output  1  checker accepts a sample this cycle
- in_a  input  WIDTH  NAND operand a
- in_b  input  WIDTH  NAND operand b
- in_y  input  WIDTH  observed NAND output
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of run
- pass_cnt  output  CNT_W  samples that matched
- fail_cnt  output  CNT_W  samples that mismatched
- err_sticky  output  1  set on any mismatch since last start
- first_fail_idx  output  CNT_W  index (0-based) of first mismatch in the run
- first_fail_y  output  WIDTH  observed y of the first mismatch
- first_fail_exp  output  WIDTH  expected y of the first mismatch

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - in_ready, busy, done and err_sticky are 0.
  - All counters and first_fail_* fields are 0.
- State machine: IDLE, RUN, DONE; the state type is an enum.
- IDLE:
  - in_ready=0.
  - start=1 with num_samples>0: clear all counters, err_sticky and first_fail_*; latch num_samples; go to RUN.
  - start=1 with num_samples==0: clear the same, go to DONE. No samples are accepted.
- RUN:
  - busy=1, in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept: exp = ~(in_a & in_b). Match -> pass_cnt+1, else fail_cnt+1.
  - Counters update at the accepting edge and are visible the next cycle.
  - On the first mismatch only: set err_sticky and capture idx=sample index, y=in_y, exp=exp. Later mismatches do not overwrite these fields.
  - When the accepted sample is index num_samples-1, go to DONE at that edge. in_ready drops the following cycle.
  - start in RUN is ignored.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, in_ready=0.
  - Then go to IDLE.
  - start in DONE is ignored.
- Results (counters, err_sticky, first_fail_*) hold until the next accepted start.
- Invariant: pass_cnt + fail_cnt == samples accepted. num_samples is at most 2^CNT_W-1, so the counters cannot wrap.
- Samples presented outside RUN are not accepted (in_ready=0). Upstream must hold in_valid and its data until accepted.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse.
- Total latency from the accepting edge to the done pulse: 1 cycle.

Decomposition:
- Shared package nand_gate_chk_pkg holds:
  - state enum typedef {IDLE, RUN, DONE};
  - default WIDTH/CNT_W localparams.
- No sub-module. The expected-value computation is a single bitwise expression inline.

Test Plan:
- Reset, start with num_samples=4, WIDTH=1, drive all four truth-table rows with correct y -> pass_cnt=4, fail_cnt=0, err_sticky=0, done pulses 1 cycle after the 4th accept.
- WIDTH=4, num_samples=3, sample 1 has a=4'hF, b=4'hF, y=4'h1 (expected 4'h0); other samples correct -> fail_cnt=1, pass_cnt=2, first_fail_idx=1, first_fail_y=4'h1, first_fail_exp=4'h0.
- Mismatches at indices 0 and 2 of num_samples=3 -> fail_cnt=2, first_fail_idx stays 0.
- start with num_samples=0 -> DONE next cycle, done=1 for one cycle, in_ready never 1, all counters 0.
- Gapped in_valid (1,0,0,1,1) with num_samples=3 -> exactly 3 accepts, in_ready=0 after DONE; extra valid samples not counted.
- Assert rst_n=0 after 2 of 5 samples -> outputs 0 immediately, no done. A new start with num_samples=1 then completes normally with pass_cnt=1.
